// File: rtl/riscv_pkg.sv
// Shared pipeline constants and the load-wait FSM state type
// used by the EX-stage forwarding / hazard unit.
package riscv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    WAIT_MEM = 1'b1
  } ld_state_e;

endpackage

// File: rtl/fwd_mux.sv
// One-slot operand forwarding mux: x0, then MEM, WB, post-WB history,
// and finally the register-file value read in ID.
module fwd_mux
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [REG_ADDR_W-1:0] rs_addr,
  input  logic [XLEN-1:0]       rs_val,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [XLEN-1:0]       mem_rd_val,
  input  logic                  wb_reg_write,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [XLEN-1:0]       wb_rd_val,
  input  logic                  hist_valid,
  input  logic [REG_ADDR_W-1:0] hist_addr,
  input  logic [XLEN-1:0]       hist_val,
  output logic [XLEN-1:0]       fwd_val
);

  // Youngest producer wins; x0 is never forwarded
  always_comb begin
    fwd_val = rs_val;
    if (rs_addr == REG_ZERO) begin
      fwd_val = '0;
    end else if (mem_reg_write && (mem_rd_addr == rs_addr)) begin
      fwd_val = mem_rd_val;
    end else if (wb_reg_write && (wb_rd_addr == rs_addr)) begin
      fwd_val = wb_rd_val;
    end else if (hist_valid && (hist_addr == rs_addr)) begin
      fwd_val = hist_val;
    end else begin
      fwd_val = rs_val;
    end
  end

endmodule

// File: rtl/fwd_hazard.sv
// EX-stage forwarding and hazard unit: per-slot forwarding, load-use
// interlock, load-wait stall with sticky timeout, and a stall counter.
module fwd_hazard
  import riscv_pkg::*;
#(
  parameter int XLEN       = XLEN_DEF,
  parameter int NUM_SRC    = 2,
  parameter int REG_BYPASS = 1,
  parameter int MAX_WAIT   = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_SRC*5-1:0]    id_rs_addr,
  input  logic [NUM_SRC-1:0]      id_rs_used,
  input  logic [NUM_SRC*5-1:0]    ex_rs_addr,
  input  logic [NUM_SRC*XLEN-1:0] ex_rs_val,
  input  logic                    ex_mem_read,
  input  logic [4:0]              ex_rd_addr,
  input  logic                    mem_reg_write,
  input  logic                    mem_mem_read,
  input  logic                    mem_load_valid,
  input  logic [4:0]              mem_rd_addr,
  input  logic [XLEN-1:0]         mem_rd_val,
  input  logic                    wb_reg_write,
  input  logic [4:0]              wb_rd_addr,
  input  logic [XLEN-1:0]         wb_rd_val,
  output logic [NUM_SRC*XLEN-1:0] ex_rs_fwd,
  output logic                    stall_if,
  output logic                    stall_id,
  output logic                    stall_ex,
  output logic                    flush_ex,
  output logic                    flush_wb,
  output logic                    load_timeout,
  output logic [31:0]             stall_cnt
);

  localparam logic [7:0] MAX_CNT = 8'(MAX_WAIT);

  ld_state_e             state_r;
  logic [7:0]            wait_cnt_r;
  logic                  hist_valid_r;
  logic [REG_ADDR_W-1:0] hist_addr_r;
  logic [XLEN-1:0]       hist_val_r;
  logic [NUM_SRC-1:0]    use_hit_s;
  logic                  load_wait_s;
  logic                  load_use_s;

  // ID slots that actually read the register the EX load is producing
  always_comb begin
    use_hit_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      use_hit_s[i] = id_rs_used[i] && (id_rs_addr[5*i +: 5] == ex_rd_addr);
    end
  end

  assign load_wait_s = mem_mem_read && !mem_load_valid;
  assign load_use_s  = !load_wait_s && ex_mem_read && (ex_rd_addr != REG_ZERO) && (|use_hit_s);

  // Stall/flush decode; a waiting load freezes EX too and bubbles WB
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_ex = 1'b0;
    flush_wb = 1'b0;
    if (load_wait_s) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      stall_ex = 1'b1;
      flush_wb = 1'b1;
    end else if (load_use_s) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end else begin
      stall_if = 1'b0;
    end
  end

  generate
    if (REG_BYPASS != 0) begin : g_hist
      // One-cycle post-WB history so the regfile needs no write-through
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          hist_valid_r <= 1'b0;
          hist_addr_r  <= REG_ZERO;
          hist_val_r   <= '0;
        end else if (wb_reg_write && (wb_rd_addr != REG_ZERO)) begin
          hist_valid_r <= 1'b1;
          hist_addr_r  <= wb_rd_addr;
          hist_val_r   <= wb_rd_val;
        end else if (stall_ex) begin
          hist_valid_r <= hist_valid_r;
        end else begin
          hist_valid_r <= 1'b0;
        end
      end
    end else begin : g_no_hist
      assign hist_valid_r = 1'b0;
      assign hist_addr_r  = REG_ZERO;
      assign hist_val_r   = '0;
    end
  endgenerate

  // Load-wait FSM: wait_cnt counts waiting cycles including the first one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= RUN;
      wait_cnt_r   <= 8'd0;
      load_timeout <= 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (load_wait_s) begin
            state_r    <= WAIT_MEM;
            wait_cnt_r <= 8'd1;
            if (MAX_CNT == 8'd1) begin
              load_timeout <= 1'b1;
            end
          end
        end
        WAIT_MEM: begin
          if (!load_wait_s) begin
            state_r    <= RUN;
            wait_cnt_r <= 8'd0;
          end else if (wait_cnt_r < MAX_CNT) begin
            wait_cnt_r <= wait_cnt_r + 8'd1;
            if ((wait_cnt_r + 8'd1) == MAX_CNT) begin
              load_timeout <= 1'b1;
            end
          end
        end
        default: begin
          state_r    <= RUN;
          wait_cnt_r <= 8'd0;
        end
      endcase
    end
  end

  // Saturating count of cycles with ID held
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 32'd0;
    end else if (stall_id && (stall_cnt != 32'hFFFF_FFFF)) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_slot
    fwd_mux #(.XLEN(XLEN)) u_fwd_mux (
      .rs_addr       (ex_rs_addr[5*g +: 5]),
      .rs_val        (ex_rs_val[XLEN*g +: XLEN]),
      .mem_reg_write (mem_reg_write),
      .mem_rd_addr   (mem_rd_addr),
      .mem_rd_val    (mem_rd_val),
      .wb_reg_write  (wb_reg_write),
      .wb_rd_addr    (wb_rd_addr),
      .wb_rd_val     (wb_rd_val),
      .hist_valid    (hist_valid_r),
      .hist_addr     (hist_addr_r),
      .hist_val      (hist_val_r),
      .fwd_val       (ex_rs_fwd[XLEN*g +: XLEN])
    );
  end

endmodule

// File: tb/tb_fwd_hazard.sv
// Bench for fwd_hazard: directed scenarios plus random traffic, all
// compared each cycle against a behavioural model of the hazard rules.
module tb_fwd_hazard;
  import riscv_pkg::*;

  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  id_rs_addr;
  logic [1:0]  id_rs_used;
  logic [9:0]  ex_rs_addr;
  logic [63:0] ex_rs_val;
  logic        ex_mem_read;
  logic [4:0]  ex_rd_addr;
  logic        mem_reg_write, mem_mem_read, mem_load_valid;
  logic [4:0]  mem_rd_addr;
  logic [31:0] mem_rd_val;
  logic        wb_reg_write;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_rd_val;
  logic [63:0] ex_rs_fwd;
  logic        stall_if, stall_id, stall_ex, flush_ex, flush_wb, load_timeout;
  logic [31:0] stall_cnt;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic        hv_m;
  logic [4:0]  ha_m;
  logic [31:0] hval_m;
  int          run_m;
  logic        to_m;
  logic [31:0] sc_m;
  logic [31:0] sc_snap;

  fwd_hazard #(.XLEN(32), .NUM_SRC(2), .REG_BYPASS(1), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs_addr(id_rs_addr), .id_rs_used(id_rs_used),
    .ex_rs_addr(ex_rs_addr), .ex_rs_val(ex_rs_val),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr),
    .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read),
    .mem_load_valid(mem_load_valid), .mem_rd_addr(mem_rd_addr), .mem_rd_val(mem_rd_val),
    .wb_reg_write(wb_reg_write), .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val),
    .ex_rs_fwd(ex_rs_fwd),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex),
    .flush_ex(flush_ex), .flush_wb(flush_wb),
    .load_timeout(load_timeout), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_fwd(input int i);
    logic [4:0] a;
    a = ex_rs_addr[5*i +: 5];
    if (a == 5'd0) return 32'd0;
    if (mem_reg_write && mem_rd_addr == a) return mem_rd_val;
    if (wb_reg_write && wb_rd_addr == a) return wb_rd_val;
    if (hv_m && ha_m == a) return hval_m;
    return ex_rs_val[32*i +: 32];
  endfunction

  task automatic idle();
    id_rs_addr = 10'd0; id_rs_used = 2'b00;
    ex_rs_addr = 10'd0; ex_rs_val = 64'd0;
    ex_mem_read = 1'b0; ex_rd_addr = 5'd0;
    mem_reg_write = 1'b0; mem_mem_read = 1'b0; mem_load_valid = 1'b0;
    mem_rd_addr = 5'd0; mem_rd_val = 32'd0;
    wb_reg_write = 1'b0; wb_rd_addr = 5'd0; wb_rd_val = 32'd0;
  endtask

  // Check all outputs against the model, then advance one clock
  task automatic step(input string tag);
    logic lw, lu;
    #1;
    lw = mem_mem_read && !mem_load_valid;
    lu = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (id_rs_used[i] && id_rs_addr[5*i +: 5] == ex_rd_addr) lu = 1'b1;
    end
    lu = lu && ex_mem_read && (ex_rd_addr != 5'd0) && !lw;
    check({tag, ".fwd0"}, ex_rs_fwd[31:0], exp_fwd(0));
    check({tag, ".fwd1"}, ex_rs_fwd[63:32], exp_fwd(1));
    check({tag, ".stall_if"}, {31'd0, stall_if}, {31'd0, lw || lu});
    check({tag, ".stall_id"}, {31'd0, stall_id}, {31'd0, lw || lu});
    check({tag, ".stall_ex"}, {31'd0, stall_ex}, {31'd0, lw});
    check({tag, ".flush_ex"}, {31'd0, flush_ex}, {31'd0, lu});
    check({tag, ".flush_wb"}, {31'd0, flush_wb}, {31'd0, lw});
    check({tag, ".timeout"}, {31'd0, load_timeout}, {31'd0, to_m});
    check({tag, ".stall_cnt"}, stall_cnt, sc_m);
    @(posedge clk);
    if (!rst_n) begin
      hv_m = 1'b0; ha_m = 5'd0; hval_m = 32'd0;
      run_m = 0; to_m = 1'b0; sc_m = 32'd0;
    end else begin
      if ((lw || lu) && sc_m != 32'hFFFF_FFFF) sc_m = sc_m + 32'd1;
      if (lw) begin
        if (run_m < MAX_WAIT) run_m = run_m + 1;
        if (run_m >= MAX_WAIT) to_m = 1'b1;
      end else begin
        run_m = 0;
      end
      if (wb_reg_write && wb_rd_addr != 5'd0) begin
        hv_m = 1'b1; ha_m = wb_rd_addr; hval_m = wb_rd_val;
      end else if (!lw) begin
        hv_m = 1'b0;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    hv_m = 1'b0; ha_m = 5'd0; hval_m = 32'd0; run_m = 0; to_m = 1'b0; sc_m = 32'd0;
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    step("rst0");
    step("rst1");
    rst_n = 1'b1;
    #1;
    check("reset_cnt", stall_cnt, 32'd0);
    check("reset_to", {31'd0, load_timeout}, 32'd0);
    step("idle");

    // zero register never forwards
    ex_rs_addr = 10'd0; mem_reg_write = 1'b1; mem_rd_addr = 5'd0; mem_rd_val = 32'hDEAD;
    #1; check("zero_reg", ex_rs_fwd[31:0], 32'd0);
    step("zero");

    // priority MEM > WB > hist > regfile
    idle();
    ex_rs_addr = {5'd0, 5'd5}; ex_rs_val = {32'd0, 32'h99};
    mem_reg_write = 1'b1; mem_rd_addr = 5'd5; mem_rd_val = 32'h11;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd5; wb_rd_val = 32'h22;
    #1; check("prio_mem", ex_rs_fwd[31:0], 32'h11);
    step("prio_mem");
    mem_reg_write = 1'b0;
    #1; check("prio_wb", ex_rs_fwd[31:0], 32'h22);
    step("prio_wb");
    wb_reg_write = 1'b0;
    step("prio_hist");
    #1; check("prio_rf", ex_rs_fwd[31:0], 32'h99);
    step("prio_rf");

    // history covers exactly one cycle after WB
    idle();
    wb_reg_write = 1'b1; wb_rd_addr = 5'd7; wb_rd_val = 32'h1234;
    step("hist_wb");
    idle();
    ex_rs_addr = {5'd7, 5'd0};
    #1; check("hist_n1", ex_rs_fwd[63:32], 32'h1234);
    step("hist_n1");
    #1; check("hist_n2", ex_rs_fwd[63:32], 32'd0);
    step("hist_n2");

    // load-use: one bubble, only when the slot is used
    idle();
    ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs_addr = {5'd3, 5'd1}; id_rs_used = 2'b10;
    sc_snap = stall_cnt;
    #1;
    check("lu_stall_id", {31'd0, stall_id}, 32'd1);
    check("lu_flush_ex", {31'd0, flush_ex}, 32'd1);
    check("lu_stall_ex", {31'd0, stall_ex}, 32'd0);
    step("lu");
    id_rs_used = 2'b00;
    #1;
    check("lu_cnt", stall_cnt, sc_snap + 32'd1);
    check("lu_unused", {31'd0, stall_id}, 32'd0);
    step("lu_unused");

    // load wait for 4 cycles
    idle();
    sc_snap = stall_cnt;
    mem_mem_read = 1'b1; mem_load_valid = 1'b0;
    ex_mem_read = 1'b1; ex_rd_addr = 5'd3; id_rs_addr = {5'd3, 5'd3}; id_rs_used = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      check("lw_flush_ex", {31'd0, flush_ex}, 32'd0);
      check("lw_flush_wb", {31'd0, flush_wb}, 32'd1);
      step("lw4");
    end
    mem_load_valid = 1'b1; ex_mem_read = 1'b0;
    #1;
    check("lw4_cnt", stall_cnt, sc_snap + 32'd4);
    check("lw4_to", {31'd0, load_timeout}, 32'd0);
    step("lw4_done");

    // long wait raises sticky timeout
    mem_load_valid = 1'b0;
    for (int k = 0; k < MAX_WAIT; k++) step("lw15");
    mem_load_valid = 1'b1;
    #1; check("to_set", {31'd0, load_timeout}, 32'd1);
    step("to_set");
    idle();
    step("to_hold0");
    #1; check("to_sticky", {31'd0, load_timeout}, 32'd1);
    step("to_hold1");

    // reset in the middle of a wait
    mem_mem_read = 1'b1; mem_load_valid = 1'b0;
    for (int k = 0; k < 3; k++) step("rw");
    rst_n = 1'b0;
    wb_reg_write = 1'b1; wb_rd_addr = 5'd9; wb_rd_val = 32'hCAFE;
    step("rw_rst");
    rst_n = 1'b1;
    idle();
    ex_rs_addr = {5'd0, 5'd9};
    #1;
    check("rw_cnt", stall_cnt, 32'd0);
    check("rw_to", {31'd0, load_timeout}, 32'd0);
    check("rw_hist", ex_rs_fwd[31:0], 32'd0);
    check("rw_stall", {31'd0, stall_id}, 32'd0);
    step("rw_after");

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      id_rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      id_rs_used     = 2'($urandom_range(0, 3));
      ex_rs_addr     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      ex_rs_val      = {$urandom, $urandom};
      ex_mem_read    = ($urandom_range(0, 2) == 0);
      ex_rd_addr     = 5'($urandom_range(0, 7));
      mem_reg_write  = $urandom_range(0, 1) == 1;
      mem_mem_read   = ($urandom_range(0, 3) == 0);
      mem_load_valid = $urandom_range(0, 1) == 1;
      mem_rd_addr    = 5'($urandom_range(0, 7));
      mem_rd_val     = $urandom;
      wb_reg_write   = $urandom_range(0, 1) == 1;
      wb_rd_addr     = 5'($urandom_range(0, 7));
      wb_rd_val      = $urandom;
      step("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
